alu_exec_unit: RTL

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// Single-issue ALU execution stage with valid/ready handshakes on both sides.
// Single-cycle ops complete on the accepting edge; mul runs as a WIDTH-step shift-add.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;
    logic             illegal_r;

    logic [WIDTH-1:0] alu_res_s;
    logic             alu_ill_s;
    logic [WIDTH-1:0] mul_sum_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             accept_mul_s;
    logic             take_s;
    logic             last_s;

    function automatic logic is_zero(input logic [WIDTH-1:0] v);
        return (v == ZERO_W);
    endfunction

    assign in_ready_s   = (state_r == ST_IDLE) && (!out_valid_r || out_ready);
    assign accept_s     = in_valid && in_ready_s;
    assign accept_mul_s = accept_s && (alu_ctrl == OP_MUL);
    assign take_s       = out_valid_r && out_ready;
    assign last_s       = (state_r == ST_MUL) && (cnt_r == CNT_LAST);
    assign mul_sum_s    = acc_r + (mplier_r[0] ? mcand_r : ZERO_W);

    // Single-cycle ALU result; illegal codes force a zero result.
    always_comb begin
        alu_res_s = ZERO_W;
        alu_ill_s = 1'b0;
        case (alu_ctrl)
            OP_ADD:  alu_res_s = src_a + src_b;
            OP_SUB:  alu_res_s = src_a - src_b;
            OP_AND:  alu_res_s = src_a & src_b;
            OP_OR:   alu_res_s = src_a | src_b;
            OP_SLT:  alu_res_s = ($signed(src_a) < $signed(src_b)) ? ONE_W : ZERO_W;
            OP_MUL:  alu_res_s = ZERO_W;
            default: begin
                alu_res_s = ZERO_W;
                alu_ill_s = 1'b1;
            end
        endcase
    end

    // Control FSM, iteration counter and busy flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_mul_s) begin
                        state_r <= ST_MUL;
                        cnt_r   <= CNT_ZERO;
                        busy_r  <= 1'b1;
                    end
                end
                ST_MUL: begin
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= CNT_ZERO;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Shift-add multiplier: operands captured at accept, one multiplier bit per MUL edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r    <= ZERO_W;
            mcand_r  <= ZERO_W;
            mplier_r <= ZERO_W;
        end else if (accept_mul_s) begin
            acc_r    <= ZERO_W;
            mcand_r  <= src_a;
            mplier_r <= src_b;
        end else if (state_r == ST_MUL) begin
            acc_r    <= mul_sum_s;
            mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
        end
    end

    // Output register: a new result wins over a transfer on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            result_r    <= ZERO_W;
            zero_r      <= 1'b0;
            illegal_r   <= 1'b0;
        end else if (accept_s && !accept_mul_s) begin
            out_valid_r <= 1'b1;
            result_r    <= alu_res_s;
            zero_r      <= is_zero(alu_res_s);
            illegal_r   <= alu_ill_s;
        end else if (last_s) begin
            out_valid_r <= 1'b1;
            result_r    <= mul_sum_s;
            zero_r      <= is_zero(mul_sum_s);
            illegal_r   <= 1'b0;
        end else if (take_s) begin
            out_valid_r <= 1'b0;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign zero      = zero_r;
    assign illegal   = illegal_r;
    assign busy      = busy_r;

endmodule
